fs32bit: RTL and testbench
==========================

Name: fs32bit

Overview:
- 4-stage pipelined 32-bit subtractor with borrow; the subtract-side counterpart of the team's pipelined 32-bit adder.
- Computes d = a - b - bin one 8-bit slice per stage, rippling the borrow between stages.
- Adds in_valid/out_valid qualification and a global stall (en), so it can sit directly in an ALU datapath next to the adder.

Parameters:
- None. Width is fixed at 32 bits and slice width at 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance; 0 = every register holds.
- in_valid  input  1  a/b/bin are valid this cycle.
- a  input  32  minuend.
- b  input  32  subtrahend.
- bin  input  1  borrow-in.
- d  output  32  difference, a - b - bin mod 2^32.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow of a - b - bin.
- out_valid  output  1  d/bout/ovf correspond to a sampled valid input.

Behaviour:
- Interface (already decided): one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - When rst=1 at a clk edge, every pipeline register clears, regardless of en.
  - d=0, bout=0, ovf=0, out_valid=0 from the following cycle.
  - Reset mid-stream drops all in-flight operations; none emerge afterwards.
- Advance rule: with rst=0 and en=1, every register updates. With en=0, every register holds, and outputs stay stable.
- Stage 0 (input regs): samples a, b, bin, in_valid.
- Stage 1: computes slice 0, {br1, d[7:0]} = a[7:0] - b[7:0] - bin. Forwards remaining slices of a and b.
- Stage 2: computes slice 1 using br1 and forwards d[7:0].
- Stage 3: same pattern for slice 2 using br2.
- Stage 4: computes slice 3 using br3.
  - bout = borrow out of bit 31.
  - ovf = (borrow into bit 31) XOR (borrow out of bit 31).
- Deskew: lower slices are delayed so that all four slices of d, plus bout, ovf and out_valid, present the same operation together.
- Latency:
  - Exactly 5 advancing edges from the sampling edge to the output.
  - Input sampled at advancing edge N appears on the outputs after advancing edge N+5.
  - Stall cycles (en=0) add no extra edges.
- Throughput: one operation per advancing cycle; back-to-back operations are independent (no borrow leakage between operations).
- Invalid operations:
  - Data with in_valid=0 is still computed, but out_valid=0 for that slot.
  - The checker ignores d/bout/ovf when out_valid=0.
- Arithmetic:
  - All slice subtraction is unsigned 8-bit with a 1-bit borrow; the borrow is 1 iff the slice minuend < subtrahend + borrow-in.
  - Wrap-around: results are mod 2^32 (e.g. 0 - 1 = 0xFFFFFFFF with bout=1).
- Simultaneous events: rst has priority over en. in_valid is ignored while en=0.

Test Plan:
- Basic subtract: a=0x00000005, b=0x00000003, bin=0 -> 5 cycles later d=0x00000002, bout=0, ovf=0, out_valid=1.
- Cross-slice borrow ripple and wrap-around:
  - a=0x00000100, b=0x00000001 -> d=0x000000FF, bout=0.
  - a=0x00000000, b=0x00000001 -> d=0xFFFFFFFF, bout=1, ovf=0.
- Signed overflow and borrow-in:
  - a=0x80000000, b=0x00000001, bin=0 -> d=0x7FFFFFFF, ovf=1, bout=0.
  - a=0x80000000, b=0x00000000, bin=1 -> d=0x7FFFFFFF, ovf=1.
  - a=b=0x12345678, bin=1 -> d=0xFFFFFFFF, bout=1, ovf=0.
- Streaming: 20 back-to-back random valid operations with random in_valid gaps -> outputs match the reference model in order, each exactly 5 advancing edges later. out_valid mirrors the in_valid pattern.
- Stall: deassert en for 3 cycles with 4 operations in flight -> outputs frozen during the stall; the same 4 results appear in order after en returns, with total latency 5 advancing edges.
- Reset mid-stream:
  - Assert rst for 1 cycle with operations in flight, also with en=0 -> next cycle d=0, bout=0, ovf=0, out_valid=0.
  - No pre-reset result appears later.
  - A new operation issued after reset completes with correct 5-cycle latency.

Source files
------------

// File: rtl/fs32bit.sv
// Four-slice pipelined 32-bit subtractor (d = a - b - bin) with valid tracking and
// a global stall. One 8-bit slice is resolved per stage; lower slices ride along deskewed.
module fs32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] d,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid
);

  // stage 0: input registers
  logic [31:0] s0_a, s0_b;
  logic        s0_bin, s0_v;

  // stage 1: slice 0 resolved
  logic [31:8]  s1_a, s1_b;
  logic [7:0]   s1_d;
  logic         s1_br, s1_v;

  // stage 2: slices 0-1 resolved
  logic [31:16] s2_a, s2_b;
  logic [15:0]  s2_d;
  logic         s2_br, s2_v;

  // stage 3: slices 0-2 resolved
  logic [31:24] s3_a, s3_b;
  logic [23:0]  s3_d;
  logic         s3_br, s3_v;

  // stage 4: full result
  logic [31:0]  s4_d;
  logic         s4_bout, s4_ovf, s4_v;

  logic [8:0]   sl0, sl1, sl2;
  logic [7:0]   lo7;
  logic         bi31, a31, b31, d31, bo31;

  always_comb begin
    sl0  = {1'b0, s0_a[7:0]}   - {1'b0, s0_b[7:0]}   - {8'b0, s0_bin};
    sl1  = {1'b0, s1_a[15:8]}  - {1'b0, s1_b[15:8]}  - {8'b0, s1_br};
    sl2  = {1'b0, s2_a[23:16]} - {1'b0, s2_b[23:16]} - {8'b0, s2_br};
    // top slice split at bit 31 so the borrow into the sign bit is visible for ovf
    lo7  = {1'b0, s3_a[30:24]} - {1'b0, s3_b[30:24]} - {7'b0, s3_br};
    bi31 = lo7[7];
    a31  = s3_a[31];
    b31  = s3_b[31];
    d31  = a31 ^ b31 ^ bi31;
    bo31 = (~a31 & b31) | (~(a31 ^ b31) & bi31);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_a <= '0; s0_b <= '0; s0_bin <= 1'b0; s0_v <= 1'b0;
      s1_a <= '0; s1_b <= '0; s1_d <= '0; s1_br <= 1'b0; s1_v <= 1'b0;
      s2_a <= '0; s2_b <= '0; s2_d <= '0; s2_br <= 1'b0; s2_v <= 1'b0;
      s3_a <= '0; s3_b <= '0; s3_d <= '0; s3_br <= 1'b0; s3_v <= 1'b0;
      s4_d <= '0; s4_bout <= 1'b0; s4_ovf <= 1'b0; s4_v <= 1'b0;
      d <= '0; bout <= 1'b0; ovf <= 1'b0; out_valid <= 1'b0;
    end else if (en) begin
      s0_a   <= a;
      s0_b   <= b;
      s0_bin <= bin;
      s0_v   <= in_valid;

      s1_a  <= s0_a[31:8];
      s1_b  <= s0_b[31:8];
      s1_d  <= sl0[7:0];
      s1_br <= sl0[8];
      s1_v  <= s0_v;

      s2_a  <= s1_a[31:16];
      s2_b  <= s1_b[31:16];
      s2_d  <= {sl1[7:0], s1_d};
      s2_br <= sl1[8];
      s2_v  <= s1_v;

      s3_a  <= s2_a[31:24];
      s3_b  <= s2_b[31:24];
      s3_d  <= {sl2[7:0], s2_d};
      s3_br <= sl2[8];
      s3_v  <= s2_v;

      s4_d    <= {d31, lo7[6:0], s3_d};
      s4_bout <= bo31;
      s4_ovf  <= bi31 ^ bo31;
      s4_v    <= s3_v;

      d         <= s4_d;
      bout      <= s4_bout;
      ovf       <= s4_ovf;
      out_valid <= s4_v;
    end
  end

endmodule

// File: tb/tb_fs32bit.sv
// Directed bench for fs32bit: hand-checked vectors plus a latency-aligned reference
// pipeline compared after every clock step.
module tb_fs32bit;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, bin;
  logic [31:0] a, b;
  logic [31:0] d;
  logic        bout, ovf, out_valid;

  int unsigned nvec = 0;
  int unsigned nmiss = 0;

  logic        ev[6];
  logic [31:0] ed[6];
  logic        eb[6], eo[6];

  fs32bit dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .bin(bin),
    .d(d), .bout(bout), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the reference pipeline shifts exactly when the DUT should.
  task automatic step();
    logic [32:0] full;
    longint      r;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin ev[i] = 1'b0; ed[i] = '0; eb[i] = 1'b0; eo[i] = 1'b0; end
    end else if (en) begin
      for (int i = 5; i > 0; i--) begin
        ev[i] = ev[i-1]; ed[i] = ed[i-1]; eb[i] = eb[i-1]; eo[i] = eo[i-1];
      end
      full  = {1'b0, a} - {1'b0, b} - {32'b0, bin};
      r     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      ev[0] = in_valid;
      ed[0] = full[31:0];
      eb[0] = full[32];
      eo[0] = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end
    @(posedge clk);
    #1;
    chk("model_valid", {31'b0, out_valid}, {31'b0, ev[5]});
    if (ev[5]) begin
      chk("model_d", d, ed[5]);
      chk("model_bout", {31'b0, bout}, {31'b0, eb[5]});
      chk("model_ovf", {31'b0, ovf}, {31'b0, eo[5]});
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vbin, input logic [31:0] xd, input logic xb, input logic xo);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_d"}, d, xd);
    chk({tag, "_bout"}, {31'b0, bout}, {31'b0, xb});
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, xo});
  endtask

  logic [31:0] snap_d;
  logic        snap_v;

  initial begin
    for (int i = 0; i < 6; i++) begin ev[i] = 1'b0; ed[i] = '0; eb[i] = 1'b0; eo[i] = 1'b0; end
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    step(); step();
    chk("reset_d", d, 32'd0);
    chk("reset_flags", {29'b0, bout, ovf, out_valid}, 32'd0);
    rst = 1'b0;

    directed("basic",     32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    directed("ripple",    32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    directed("wrap",      32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    directed("ovf_sub",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    directed("ovf_bin",   32'h8000_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    directed("equal_bin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // streaming with random valid gaps
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // stall with four operations in flight; in_valid during stall must be ignored
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; bin = 1'(i & 1); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    snap_d = d; snap_v = out_valid;
    en = 1'b0; in_valid = 1'b1; a = $urandom; b = $urandom;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_d", d, snap_d);
      chk("stall_valid", {31'b0, out_valid}, {31'b0, snap_v});
    end
    en = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // reset mid-stream while stalled
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; bin = 1'b1; in_valid = 1'b1;
      step();
    end
    en = 1'b0; rst = 1'b1;
    step();
    chk("midrst_d", d, 32'd0);
    chk("midrst_flags", {29'b0, bout, ovf, out_valid}, 32'd0);
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", {31'b0, out_valid}, 32'd0);
    end
    directed("post_rst",  32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
